piece_bag: RTL and testbench
============================

# piece_bag

Consumer of the LFSR random stream. Converts raw `random_o`/`v_o` words into a fair 7-bag sequence of tetromino IDs. Each bag holds all seven pieces exactly once. The block keeps a small lookahead queue so the game FSM can pop the current piece while the display shows the upcoming ones. It sits between the random generator and the game control/spawn logic.

## Interface
Parameters:
- `rand_width_p`, default 65: width of the incoming random word; must be ≥ 8 (elaboration error otherwise).
- `preview_p`, default 3: number of upcoming pieces exposed beyond the head; queue depth is `preview_p+1`.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `random_i`  in  `rand_width_p`  random word from the generator.
- `random_v_i`  in  1  random word valid (generator `v_o`).
- `restart_i`  in  1  new game: flush queue and bag.
- `piece_o`  out  3  head piece ID.
- `piece_v_o`  out  1  head valid.
- `piece_yumi_i`  in  1  consumer pops head. Legal only when `piece_v_o` is high.
- `preview_o`  out  `3*preview_p`  queue entries 1..`preview_p`; entry 1 is in bits [2:0].
- `preview_v_o`  out  `preview_p`  per-entry valid.

## Operation
- Piece encoding: 0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L. The value 7 is never produced.
- State:
  - `used_r[6:0]`: pieces already drawn from the current bag.
  - Queue: `preview_p+1` entries of 3 bits, FIFO order.
  - `count_r`: number of valid entries in the queue.
- Push condition: `random_v_i && (count_r < preview_p+1 || piece_yumi_i)`. At most one push per cycle. Each random word is used at most once and is never stored.
- Draw computation (all values unsigned):
  - `remaining = 7 - popcount(used_r)`, range 1..7.
  - `k = random_i[7:0] mod remaining`.
  - The drawn piece is the index of the k-th zero bit of `used_r`, counting from bit 0 upward with k = 0 meaning the first zero bit.
- On push:
  - Set `used_r[piece]`.
  - If that makes `used_r` equal to 7'h7F, clear `used_r` to 0 in the same update, which starts a new bag.
  - Append the piece at the queue tail.
- Pop (`piece_yumi_i`): remove the head; remaining entries shift toward the head.
  - Simultaneous pop and push: count is unchanged, and the new piece lands at the tail after the shift.
  - Simultaneous pop and push on a full queue is legal.
- `piece_yumi_i` while `piece_v_o` is low is a protocol error. The block ignores it: no state change.
- Priority: `reset_i` > `restart_i` > pop/push.
- `restart_i`: sets `count_r`=0 and `used_r`=0, and clears all entries to 0. The random word in that cycle is discarded, as is any yumi in that cycle.

## Timing
- Reset values: `piece_o`=0, `piece_v_o`=0, `preview_o`=0, `preview_v_o`=0; internally `used_r`=0 and `count_r`=0.
- All outputs are register-driven. No combinational path from `random_i`, `random_v_i` or `piece_yumi_i` to any output.
- `piece_v_o` = (`count_r` ≥ 1). `preview_v_o[i-1]` = (`count_r` ≥ i+1).
- Invalid entries always read as 0.
- Latency:
  - A word accepted in cycle t appears in the queue at t+1.
  - An empty queue fed with `random_v_i` held high is full after `preview_p+1` cycles.
- Pop in cycle t: the new head is visible at t+1.
- Full queue with no pop: `random_i` is ignored and `used_r` is held.
- Bag boundary: the 7th draw of a bag and the 1st draw of the next bag may occur on consecutive cycles with no bubble.
- A random word is used at most once per cycle even if it stays unchanged across cycles; the generator advances every cycle, so this is never a concern.

## Test plan
- Reset, then `random_v_i`=1 with `random_i[7:0]`=10 → `remaining`=7, k=3 → piece 3 appears at the head one cycle later with `piece_v_o`=1. Outputs are 0 before that.
- Continue from the previous state (`used_r`={3}) with `random_i[7:0]`=0, then 0, 0, 0, 0, 0 → pieces 0,1,2,4,5,6 in order, then `used_r` returns to 0. With depth 4 (`preview_p`=3) the queue fills after 4 pushes. Pop one per cycle so all 7 draws are accepted, and check the last entry. Then a word of 255 → 255 mod 7 = 3 → piece 3 (new bag).
- Full queue (depth 4), no pop, 10 cycles of varying `random_i` → queue contents and `used_r` unchanged. Then one cycle of pop plus push → `count_r` stays 4, head shifts, new piece at the tail.
- Randomized stream of 700 pops with the generator connected → every aligned group of 7 consecutive pops is a permutation of 0..6, and piece 7 never appears.
- `restart_i` asserted together with `piece_yumi_i` and `random_v_i` on a half-full queue → next cycle `piece_v_o`=0, `preview_v_o`=0, all outputs 0. The first following draw uses `remaining`=7.
- `reset_i` asserted mid-bag while pushing, and `piece_yumi_i` asserted while empty → all outputs return to their reset values, and the illegal yumi causes no underflow (`count_r` stays 0).

Source files
------------

// File: rtl/piece_bag_if.sv
// rtl/piece_bag_if.sv - random-word input and piece/preview output bundle for piece_bag
interface piece_bag_if #(
    parameter int rand_width_p = 65,
    parameter int preview_p    = 3
);
    logic [rand_width_p-1:0] random_i;
    logic                    random_v_i;
    logic [2:0]              piece_o;
    logic                    piece_v_o;
    logic                    piece_yumi_i;
    logic [3*preview_p-1:0]  preview_o;
    logic [preview_p-1:0]    preview_v_o;

    // master is the bag itself; slave is the generator/game side that feeds and pops it
    modport master (
        input  random_i, random_v_i, piece_yumi_i,
        output piece_o, piece_v_o, preview_o, preview_v_o
    );

    modport slave (
        output random_i, random_v_i, piece_yumi_i,
        input  piece_o, piece_v_o, preview_o, preview_v_o
    );
endinterface

// File: rtl/piece_bag.sv
// rtl/piece_bag.sv - 7-bag tetromino randomizer with a preview_p+1 deep lookahead queue
module piece_bag #(
    parameter int rand_width_p = 65,
    parameter int preview_p    = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        restart_i,
    piece_bag_if.master bus
);
    localparam int depth_lp = preview_p + 1;
    localparam int cnt_w_lp = $clog2(depth_lp + 1);

    if (rand_width_p < 8) begin : g_bad_width
        $error("piece_bag: rand_width_p must be at least 8");
    end

    // only the low byte of the random word picks the piece
    if (rand_width_p > 8) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^bus.random_i[rand_width_p-1:8];
    end

    logic [2:0]          q_r [depth_lp];
    logic [2:0]          q_n [depth_lp];
    logic [cnt_w_lp-1:0] count_r, count_n, base;
    logic [depth_lp-1:0] valid_r, valid_n;
    logic [6:0]          used_r, used_n, used_set;
    logic                pop, push, found;
    logic [2:0]          ones, remaining, draw;
    logic [7:0]          k, seen;

    always_comb begin
        pop  = bus.piece_yumi_i & valid_r[0];
        push = bus.random_v_i & ((count_r < cnt_w_lp'(depth_lp)) | pop);

        ones = 3'd0;
        for (int i = 0; i < 7; i++) begin
            ones = ones + {2'b00, used_r[i]};
        end
        remaining = 3'd7 - ones;
        k = bus.random_i[7:0] % {5'd0, remaining};

        // walk the free slots of the bag and take the k-th one
        seen  = 8'd0;
        draw  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!used_r[i]) begin
                if (!found && seen == k) begin
                    draw  = 3'(i);
                    found = 1'b1;
                end
                seen = seen + 8'd1;
            end
        end

        q_n = q_r;
        if (pop) begin
            for (int i = 0; i < depth_lp - 1; i++) begin
                q_n[i] = q_r[i+1];
            end
            q_n[depth_lp-1] = 3'd0;
        end

        base = count_r - {{(cnt_w_lp-1){1'b0}}, pop};
        for (int i = 0; i < depth_lp; i++) begin
            if (push && base == cnt_w_lp'(i)) begin
                q_n[i] = draw;
            end
        end
        count_n = base + {{(cnt_w_lp-1){1'b0}}, push};

        for (int i = 0; i < depth_lp; i++) begin
            valid_n[i] = count_n > cnt_w_lp'(i);
        end

        used_set = used_r | (7'd1 << draw);
        used_n   = used_r;
        if (push) begin
            used_n = (used_set == 7'h7F) ? 7'd0 : used_set;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || restart_i) begin
            count_r <= '0;
            valid_r <= '0;
            used_r  <= '0;
            for (int i = 0; i < depth_lp; i++) begin
                q_r[i] <= 3'd0;
            end
        end else begin
            count_r <= count_n;
            valid_r <= valid_n;
            used_r  <= used_n;
            for (int i = 0; i < depth_lp; i++) begin
                q_r[i] <= q_n[i];
            end
        end
    end

    assign bus.piece_o     = q_r[0];
    assign bus.piece_v_o   = valid_r[0];
    assign bus.preview_v_o = valid_r[depth_lp-1:1];

    for (genvar g = 0; g < preview_p; g++) begin : g_preview
        assign bus.preview_o[3*g +: 3] = q_r[g+1];
    end
endmodule

// File: tb/tb_piece_bag.sv
// tb/tb_piece_bag.sv - directed-vector bench for piece_bag
module tb_piece_bag;
    logic clk = 1'b0;
    logic rst;
    logic restart;
    int   total = 0;
    int   bad   = 0;
    int   pops [700];
    int   npops;

    always #5 clk = ~clk;

    piece_bag_if #(.rand_width_p(65), .preview_p(3)) bif ();

    piece_bag #(.rand_width_p(65), .preview_p(3)) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .restart_i (restart),
        .bus       (bif.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_v"},    32'(bif.piece_v_o),   32'd0);
        check({tag, "_p"},    32'(bif.piece_o),     32'd0);
        check({tag, "_pv"},   32'(bif.preview_v_o), 32'd0);
        check({tag, "_prev"}, 32'(bif.preview_o),   32'd0);
    endtask

    initial begin
        rst = 1'b1;
        restart = 1'b0;
        bif.random_i = '0;
        bif.random_v_i = 1'b0;
        bif.piece_yumi_i = 1'b0;
        step();
        step();
        check_idle("reset");

        // first draw: 10 mod 7 = 3 -> piece 3
        rst = 1'b0;
        bif.random_v_i = 1'b1;
        bif.random_i = 65'd10;
        #1;
        check("no_comb_path", 32'(bif.piece_v_o), 32'd0);
        step();
        bif.random_v_i = 1'b0;
        check("first_piece", 32'(bif.piece_o), 32'd3);
        check("first_v", 32'(bif.piece_v_o), 32'd1);
        check("first_pv", 32'(bif.preview_v_o), 32'd0);

        // three zero words fill the queue with 0,1,2 behind the 3
        bif.random_v_i = 1'b1;
        bif.random_i = 65'd0;
        step();
        step();
        step();
        check("full_head", 32'(bif.piece_o), 32'd3);
        check("full_prev", 32'(bif.preview_o), 32'h088);
        check("full_pv", 32'(bif.preview_v_o), 32'h7);

        // full queue, no pop: nothing changes
        for (int i = 0; i < 10; i++) begin
            bif.random_i = 65'({$urandom(), $urandom(), $urandom()});
            step();
            check("hold", {16'd0, 4'(bif.piece_o), 9'(bif.preview_o), 3'(bif.preview_v_o)},
                  {16'd0, 4'd3, 9'h088, 3'h7});
        end

        // pop+push on full: remaining slots {4,5,6}, k=0 -> 4
        bif.random_i = 65'd0;
        bif.piece_yumi_i = 1'b1;
        step();
        check("popush_head", 32'(bif.piece_o), 32'd0);
        check("popush_prev", 32'(bif.preview_o), 32'h111);
        check("popush_pv", 32'(bif.preview_v_o), 32'h7);
        step();
        step();
        // bag closes with 6; next word 255 mod 7 = 3 starts a new bag without a bubble
        bif.random_i = 65'd255;
        step();
        check("newbag_head", 32'(bif.piece_o), 32'd4);
        check("newbag_prev", 32'(bif.preview_o), 32'h0F5);

        // drain to empty
        bif.random_v_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_idle("drained");

        // illegal yumi while empty must not underflow
        step();
        check("illegal_yumi_v", 32'(bif.piece_v_o), 32'd0);
        bif.piece_yumi_i = 1'b0;
        bif.random_v_i = 1'b1;
        bif.random_i = 65'd10;
        step();
        // bag holds {3}: free 0,1,2,4,5,6, 10 mod 6 = 4 -> 5
        check("after_illegal", 32'(bif.piece_o), 32'd5);
        check("after_illegal_pv", 32'(bif.preview_v_o), 32'd0);
        bif.random_i = 65'd0;
        step();
        check("half_pv", 32'(bif.preview_v_o), 32'h1);

        // restart with yumi and a valid word on a half-full queue
        restart = 1'b1;
        bif.piece_yumi_i = 1'b1;
        step();
        restart = 1'b0;
        bif.piece_yumi_i = 1'b0;
        bif.random_v_i = 1'b0;
        check_idle("restart");
        bif.random_v_i = 1'b1;
        bif.random_i = 65'd10;
        step();
        bif.random_v_i = 1'b0;
        check("restart_draw", 32'(bif.piece_o), 32'd3);

        // reset mid-bag while pushing and popping
        bif.random_v_i = 1'b1;
        bif.random_i = 65'd0;
        step();
        rst = 1'b1;
        bif.piece_yumi_i = 1'b1;
        step();
        rst = 1'b0;
        bif.random_v_i = 1'b0;
        check_idle("midreset");
        step();
        check("midreset_yumi_v", 32'(bif.piece_v_o), 32'd0);
        bif.piece_yumi_i = 1'b0;
        bif.random_v_i = 1'b1;
        bif.random_i = 65'd10;
        step();
        bif.random_v_i = 1'b0;
        check("midreset_draw", 32'(bif.piece_o), 32'd3);
        check("midreset_pv", 32'(bif.preview_v_o), 32'd0);

        // random stream: every aligned group of 7 pops is one bag
        restart = 1'b1;
        step();
        restart = 1'b0;
        npops = 0;
        bif.random_v_i = 1'b1;
        for (int cyc = 0; cyc < 3000 && npops < 700; cyc++) begin
            bif.random_i = 65'({$urandom(), $urandom(), $urandom()});
            bif.piece_yumi_i = bif.piece_v_o;
            if (bif.piece_v_o) begin
                pops[npops] = int'(bif.piece_o);
                npops++;
            end
            step();
        end
        bif.random_v_i = 1'b0;
        bif.piece_yumi_i = 1'b0;
        check("pop_count", 32'(npops), 32'd700);
        for (int g = 0; g + 7 <= npops; g += 7) begin
            logic [7:0] mask;
            mask = 8'd0;
            for (int j = 0; j < 7; j++) begin
                mask[pops[g+j][2:0]] = 1'b1;
            end
            check("bag_perm", 32'(mask), 32'h7F);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
